ids_dma_engine: RTL and testbench
=================================

# ids_dma_engine

Single-channel word-copy DMA master for the IDS SoC data side. The core configures it through a small register port. It then drives the DMA requester port of the shared data bus (`i_req_dma`/`o_gnt_dma` side of the bus arbiter) to move a block of 32-bit words from a source region to a destination region. Typical use is PIM buffer (0x2xxx_xxxx) to Hybrid-PIM (0x4xxx_xxxx). The engine has the lowest bus priority and must tolerate losing grant on any cycle.

## Interface
Parameters:
- LEN_W, 16, width of the transfer length register (words).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cfg_write  in  1  register write strobe from core.
- i_cfg_addr  in  4  register byte offset; bits [3:2] select the register.
- i_cfg_din  in  32  register write data.
- o_cfg_dout  out  32  combinational read data for `i_cfg_addr`.
- o_req_dma  out  1  bus request.
- i_gnt_dma  in  1  bus grant; a beat is accepted in a cycle with `o_req_dma && i_gnt_dma`.
- o_dma_addr  out  32  bus address.
- o_dma_read  out  1  read strobe.
- o_dma_write  out  1  write strobe.
- o_dma_size  out  4  access size, fixed 4'b1111 (full word) whenever read or write is high, else 0.
- o_dma_din  out  32  write data.
- i_dma_dout  in  32  read data, valid the cycle after an accepted read.
- o_irq  out  1  transfer-complete interrupt (see Configuration).

## Operation
Register map by `i_cfg_addr[3:2]`:
- 0: SRC.
- 1: DST.
- 2: LEN[LEN_W-1:0], zero-extended on read.
- 3: CTRL/STATUS.
  - Write: bit0 = start, bit1 = clear done.
  - Read: bit0 = busy, bit1 = done, bits [31:16] = remaining word count.

Register write rules:
- Writes to SRC/DST/LEN while busy are ignored.
- Start while busy is ignored.
- Start and clear-done in the same write: done is cleared, then the transfer starts.

States:
- IDLE
  - Bus outputs are 0.
  - On start: latch working copies src_q=SRC, dst_q=DST, cnt_q=LEN, and clear done.
  - Go to RD if LEN≠0; otherwise go to FIN.
- RD
  - Drive req=1, read=1, addr=src_q.
  - Hold all outputs until a cycle where grant is high, then go to WAIT.
- WAIT
  - req=0, read=0, write=0, addr held at src_q.
  - Capture `i_dma_dout` into data_q.
  - src_q += 4, then go to WR.
- WR
  - Drive req=1, write=1, addr=dst_q, din=data_q.
  - Hold all outputs until grant.
  - On acceptance: dst_q += 4, cnt_q -= 1.
  - Go to RD if the new cnt_q≠0; otherwise go to FIN.
- FIN
  - Set done, pulse irq, then go to IDLE.

Rules:
- Address arithmetic is modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0. No alignment checking: the low two bits of SRC/DST are forwarded unchanged.
- busy = (state≠IDLE).
- done stays set until cleared by CTRL bit1 or by a new start.
- Reset mid-transfer returns to IDLE immediately with all registers cleared; no partial-beat completion.

## Timing
Reset values:
- All registers, state, and counters: 0.
- All outputs: 0. o_cfg_dout is 0 only for selected registers that are themselves 0.

Transfer timing:
- A start written in cycle N drives o_req_dma high in cycle N+1.
- Best-case throughput (grant always high) is 3 cycles per word: RD, WAIT, WR.
- With LEN=L and no stalls, done reads 1 in cycle N+2+3L.
- The irq pulse is exactly 1 cycle, in the FIN cycle.
- Grant loss stalls RD or WR indefinitely with all outputs stable.
- WAIT never stalls. The bus registers the address every cycle, so `o_dma_addr` must remain the read address during WAIT.
- A start with LEN=0 goes IDLE→FIN→IDLE, with done set in cycle N+2.

## Configuration
- IDS_DMA_IRQ_EN
  - Defined: o_irq pulses high for one cycle on every FIN.
  - Undefined: o_irq is tied to 0 and no irq logic is instantiated. Status polling via CTRL/STATUS is unaffected.

## Test plan
- SRC=0x2000_0000, DST=0x4000_0000, LEN=4, grant held 1, then start → four read/write pairs at src +0,4,8,C and dst +0,4,8,C. Written data equals the data returned. done=1 at start+14.
- Same setup, with grant dropped for 5 cycles during the second WR → outputs stable throughout, the transfer completes correctly, and done arrives 5 cycles later.
- LEN=0, then start → no bus request asserted. done=1 two cycles after start. irq pulses when IDS_DMA_IRQ_EN is defined.
- Mid-transfer writes of SRC=0xDEAD_0000 and a second start → ignored. The original transfer completes and SRC still reads the old value.
- SRC=0xFFFF_FFF8, LEN=3 → read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert i_rst_n=0 during WR → all outputs 0 asynchronously. After release, busy=0, done=0, and the remaining count reads 0.

Source files
------------

// File: rtl/ids_dma_engine.sv
// Single-channel word-copy DMA master for the IDS data bus (lowest-priority requester).
// Define IDS_DMA_IRQ_EN to drive o_irq on transfer completion; otherwise o_irq is tied low.
module ids_dma_engine #(
  parameter int LEN_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_write,
  input  logic [3:0]  i_cfg_addr,
  input  logic [31:0] i_cfg_din,
  output logic [31:0] o_cfg_dout,
  output logic        o_req_dma,
  input  logic        i_gnt_dma,
  output logic [31:0] o_dma_addr,
  output logic        o_dma_read,
  output logic        o_dma_write,
  output logic [3:0]  o_dma_size,
  output logic [31:0] o_dma_din,
  input  logic [31:0] i_dma_dout,
  output logic        o_irq
);

  // state  | meaning
  // S_IDLE | no transfer; bus outputs quiet
  // S_RD   | read request at src_q, held until granted
  // S_WAIT | read data returns; address still held at src_q
  // S_WR   | write request of data_q at dst_q, held until granted
  // S_FIN  | one-cycle completion: set done, pulse irq
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_src;
  logic [31:0]       r_dst;
  logic [LEN_W-1:0]  r_len;
  logic              r_done;
  logic [31:0]       r_src_q;
  logic [31:0]       r_dst_q;
  logic [LEN_W-1:0]  r_cnt_q;
  logic [31:0]       r_data_q;

  logic [1:0]        w_sel;
  logic              w_busy;
  logic              w_start;
  logic              w_clr;
  logic [15:0]       w_cnt16;
  logic              w_unused_addr;

  assign w_sel         = i_cfg_addr[3:2];
  assign w_busy        = (r_state != S_IDLE);
  assign w_start       = i_cfg_write && (w_sel == 2'd3) && i_cfg_din[0] && !w_busy;
  assign w_clr         = i_cfg_write && (w_sel == 2'd3) && i_cfg_din[1];
  assign w_cnt16       = 16'(r_cnt_q);
  assign w_unused_addr = ^i_cfg_addr[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
    end else if (i_cfg_write && !w_busy) begin
      case (w_sel)
        2'd0:    r_src <= i_cfg_din;
        2'd1:    r_dst <= i_cfg_din;
        2'd2:    r_len <= i_cfg_din[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  // FIN can never coincide with an accepted start, so set-over-clear only matters vs. clear-done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_done <= 1'b0;
    else if (r_state == S_FIN)
      r_done <= 1'b1;
    else if (w_clr || w_start)
      r_done <= 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_src_q  <= '0;
      r_dst_q  <= '0;
      r_cnt_q  <= '0;
      r_data_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_src_q <= r_src;
          r_dst_q <= r_dst;
          r_cnt_q <= r_len;
        end
        S_WAIT: begin
          r_data_q <= i_dma_dout;
          r_src_q  <= r_src_q + 32'd4;
        end
        S_WR: if (i_gnt_dma) begin
          r_dst_q <= r_dst_q + 32'd4;
          r_cnt_q <= r_cnt_q - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_dma   = 1'b0;
    o_dma_read  = 1'b0;
    o_dma_write = 1'b0;
    o_dma_size  = 4'h0;
    o_dma_addr  = 32'h0;
    o_dma_din   = 32'h0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = (r_len != '0) ? S_RD : S_FIN;
      S_RD: begin
        o_req_dma  = 1'b1;
        o_dma_read = 1'b1;
        o_dma_size = 4'hF;
        o_dma_addr = r_src_q;
        if (i_gnt_dma) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_dma_addr  = r_src_q;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        o_req_dma   = 1'b1;
        o_dma_write = 1'b1;
        o_dma_size  = 4'hF;
        o_dma_addr  = r_dst_q;
        o_dma_din   = r_data_q;
        // the word being written is the last one when the pre-decrement count is 1
        if (i_gnt_dma) w_state_nxt = (r_cnt_q == LEN_W'(1)) ? S_FIN : S_RD;
      end
      S_FIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_cfg_dout = 32'h0;
    case (w_sel)
      2'd0: o_cfg_dout = r_src;
      2'd1: o_cfg_dout = r_dst;
      2'd2: o_cfg_dout = 32'(r_len);
      2'd3: o_cfg_dout = {w_cnt16, 14'h0, r_done, w_busy};
      default: o_cfg_dout = 32'h0;
    endcase
  end

`ifdef IDS_DMA_IRQ_EN
  assign o_irq = (r_state == S_FIN);
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_ids_dma_engine.sv
// Scoreboard bench for ids_dma_engine: expected beats queued at setup, popped as the bus model accepts them.
module tb_ids_dma_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_write = 1'b0;
  logic [3:0]  cfg_addr = 4'hC;
  logic [31:0] cfg_din = '0;
  logic [31:0] cfg_dout;
  logic        req, gnt = 1'b1;
  logic [31:0] dma_addr, dma_din;
  logic        dma_read, dma_write, irq;
  logic [3:0]  dma_size;
  logic [31:0] dma_dout = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] q_rd[$], q_wdst[$], q_wdata[$];

  ids_dma_engine #(.LEN_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_write(cfg_write), .i_cfg_addr(cfg_addr),
    .i_cfg_din(cfg_din), .o_cfg_dout(cfg_dout), .o_req_dma(req), .i_gnt_dma(gnt),
    .o_dma_addr(dma_addr), .o_dma_read(dma_read), .o_dma_write(dma_write),
    .o_dma_size(dma_size), .o_dma_din(dma_din), .i_dma_dout(dma_dout), .o_irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_write = 1'b1; cfg_addr = a; cfg_din = d;
    @(negedge clk);
    cfg_write = 1'b0; cfg_addr = 4'hC;
  endtask

  task automatic cfg_rd(input logic [3:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1 d = cfg_dout;
    cfg_addr = 4'hC;
  endtask

  task automatic setup(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] rd;
    cfg_wr(4'h0, src);
    cfg_wr(4'h4, dst);
    cfg_wr(4'h8, 32'(len));
    cfg_rd(4'h8, rd);
    checks++;
    if (rd !== 32'(len)) begin errors++; $display("FAIL len_readback got=%h exp=%h", rd, 32'(len)); end
    q_rd.delete(); q_wdst.delete(); q_wdata.delete();
    for (int i = 0; i < len; i++) begin
      q_rd.push_back(src + 32'(4 * i));
      q_wdst.push_back(dst + 32'(4 * i));
      q_wdata.push_back(mem_val(src + 32'(4 * i)));
    end
  endtask

  // Entered at the negedge of the cycle after the start write (cycle 1).
  task automatic run_xfer(input string name, input int stall_idx, input int stall_len,
                          input int exp_done, input bit busy_writes);
    int wr_cnt = 0, stall_ctr = 0, irq_cnt = 0, irq_cyc = -1, done_cyc = -1;
    bit pend = 0, prev_stall = 0, prev_rd_acc = 0;
    logic [31:0] pend_a = '0, prev_addr = '0, prev_din = '0, e;
    logic prev_rd = 0, prev_wr = 0, g;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (pend) begin dma_dout = mem_val(pend_a); pend = 0; end
      else dma_dout = $urandom;
      if (busy_writes && cyc == 4) begin cfg_write = 1; cfg_addr = 4'h0; cfg_din = 32'hDEAD_0000; end
      else if (busy_writes && cyc == 5) begin cfg_write = 1; cfg_addr = 4'hC; cfg_din = 32'h1; end
      else begin cfg_write = 0; cfg_addr = 4'hC; end
      #1;
      checks++;
      if (dma_size !== ((dma_read || dma_write) ? 4'hF : 4'h0)) begin
        errors++; $display("FAIL %s size cyc=%0d got=%h", name, cyc, dma_size);
      end
      if (prev_stall) begin
        checks++;
        if (req !== 1'b1 || dma_read !== prev_rd || dma_write !== prev_wr ||
            dma_addr !== prev_addr || dma_din !== prev_din) begin
          errors++; $display("FAIL %s stall_stable cyc=%0d addr=%h exp=%h din=%h exp=%h",
                             name, cyc, dma_addr, prev_addr, dma_din, prev_din);
        end
      end
      if (prev_rd_acc) begin
        checks++;
        if (req !== 1'b0 || dma_read !== 1'b0 || dma_write !== 1'b0 || dma_addr !== prev_addr) begin
          errors++; $display("FAIL %s wait_addr cyc=%0d got=%h exp=%h req=%b", name, cyc, dma_addr, prev_addr, req);
        end
      end
      if (irq) begin irq_cnt++; irq_cyc = cyc; end
      if (cfg_addr == 4'hC && !cfg_write && cfg_dout[1] && done_cyc < 0) done_cyc = cyc;
      g = 1'b1;
      if (req && dma_write && wr_cnt == stall_idx && stall_ctr < stall_len) begin g = 1'b0; stall_ctr++; end
      gnt = g;
      if (req && g && dma_read) begin
        checks++;
        if (q_rd.size() == 0) begin errors++; $display("FAIL %s unexpected_read addr=%h", name, dma_addr); end
        else begin
          e = q_rd.pop_front();
          if (dma_addr !== e) begin errors++; $display("FAIL %s rd_addr got=%h exp=%h", name, dma_addr, e); end
        end
        pend = 1; pend_a = dma_addr;
      end
      if (req && g && dma_write) begin
        checks++;
        if (q_wdst.size() == 0) begin errors++; $display("FAIL %s unexpected_write addr=%h", name, dma_addr); end
        else begin
          e = q_wdst.pop_front();
          if (dma_addr !== e) begin errors++; $display("FAIL %s wr_addr got=%h exp=%h", name, dma_addr, e); end
          e = q_wdata.pop_front();
          if (dma_din !== e) begin errors++; $display("FAIL %s wr_data got=%h exp=%h", name, dma_din, e); end
        end
        wr_cnt++;
      end
      prev_stall = req && !g;
      prev_rd_acc = req && g && dma_read;
      prev_rd = dma_read; prev_wr = dma_write; prev_addr = dma_addr; prev_din = dma_din;
      if (done_cyc >= 0) break;
      @(negedge clk);
    end
    gnt = 1'b1;
    checks++;
    if (done_cyc !== exp_done) begin errors++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc, exp_done); end
    checks++;
    if (q_rd.size() != 0 || q_wdst.size() != 0) begin
      errors++; $display("FAIL %s beats_left rd=%0d wr=%0d exp=0", name, q_rd.size(), q_wdst.size());
    end
    checks++;
`ifdef IDS_DMA_IRQ_EN
    if (irq_cnt != 1 || irq_cyc != exp_done - 1) begin
      errors++; $display("FAIL %s irq count=%0d cyc=%0d exp 1 at %0d", name, irq_cnt, irq_cyc, exp_done - 1);
    end
`else
    if (irq_cnt != 0) begin errors++; $display("FAIL %s irq count=%0d exp=0", name, irq_cnt); end
`endif
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    checks++;
    if (req !== 0 || dma_read !== 0 || dma_write !== 0 || dma_addr !== 0 ||
        dma_din !== 0 || dma_size !== 0 || irq !== 0) begin
      errors++; $display("FAIL reset_outputs req=%b rd=%b wr=%b addr=%h", req, dma_read, dma_write, dma_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_rd(4'(i * 4), rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", i, rd); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    setup(32'h2000_0000, 32'h4000_0000, 4);
    cfg_rd(4'h0, rd);
    checks++;
    if (rd !== 32'h2000_0000) begin errors++; $display("FAIL src_readback got=%h exp=20000000", rd); end
    cfg_wr(4'hC, 32'h1);
    run_xfer("basic", -1, 0, 14, 0);
    cfg_wr(4'hC, 32'h2);
    cfg_rd(4'hC, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL clear_done status=%h exp=0", rd); end
  endtask

  task automatic test_stall();
    setup(32'h2000_0000, 32'h4000_0000, 4);
    cfg_wr(4'hC, 32'h3);
    run_xfer("stall", 1, 5, 19, 0);
  endtask

  task automatic test_len0();
    setup(32'h2000_0100, 32'h4000_0100, 0);
    cfg_wr(4'hC, 32'h1);
    run_xfer("len0", -1, 0, 2, 0);
  endtask

  task automatic test_busy_writes();
    logic [31:0] rd;
    setup(32'h2000_0040, 32'h4000_0080, 4);
    cfg_wr(4'hC, 32'h1);
    run_xfer("busy_wr", -1, 0, 14, 1);
    cfg_rd(4'h0, rd);
    checks++;
    if (rd !== 32'h2000_0040) begin errors++; $display("FAIL busy_src_kept got=%h exp=20000040", rd); end
  endtask

  task automatic test_wrap();
    setup(32'hFFFF_FFF8, 32'h4000_0200, 3);
    cfg_wr(4'hC, 32'h1);
    run_xfer("wrap", -1, 0, 11, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bit found = 0;
    cfg_wr(4'h0, 32'h2000_0000);
    cfg_wr(4'h8, 32'h4);
    cfg_wr(4'hC, 32'h1);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req && dma_write) begin gnt = 1'b0; found = 1; break; end
      gnt = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_mid reach_wr got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 0 || dma_read !== 0 || dma_write !== 0 || dma_addr !== 0 ||
        dma_din !== 0 || dma_size !== 0 || irq !== 0 || cfg_dout !== 0) begin
      errors++; $display("FAIL rst_mid_outputs req=%b wr=%b addr=%h din=%h status=%h exp all 0",
                         req, dma_write, dma_addr, dma_din, cfg_dout);
    end
    gnt = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    cfg_rd(4'hC, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_status got=%h exp=0", rd); end
    cfg_rd(4'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_src got=%h exp=0", rd); end
  endtask

  initial begin
    #23;
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_busy_writes();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
